traffic_display_ctrl: RTL
=========================

Name: traffic_display_ctrl

Overview:
- Parametrised traffic-light sequencer with an integrated multiplexed seven-segment countdown display.
- Phase durations, tick and scan dividers, and digit count are all parameters.
- Adds a pedestrian request that shortens green, and a hold input that freezes the sequence.
- Sits directly under the board top, driven from the single fast board clock.

Parameters:
- TICK_DIV, 50_000_000, fast_clk cycles per 1-second tick (>=2).
- SCAN_DIV, 50_000, fast_clk cycles per display digit slot (>=1).
- RED_T, 10, red phase length in ticks (1..99).
- GREEN_T, 8, green phase length in ticks (1..99).
- YELLOW_T, 3, yellow phase length in ticks (1..99).
- PED_MIN, 2, green remaining value forced on a pedestrian request (1..GREEN_T).
- NUM_DIGITS, 4, display digits (>=3).

Ports:
- fast_clk  in  1  sole clock.
- rst  in  1  synchronous, active-high reset.
- ped_req  in  1  pedestrian request, level, sampled each cycle.
- hold  in  1  freeze countdown and phase while high.
- light  out  [0:2]  one-hot lamps: light[0]=red, light[1]=yellow, light[2]=green.
- clock  out  1  1-cycle pulse on each tick.
- phase  out  2  00=RED, 01=GREEN, 10=YELLOW.
- seg  out  8  {dp,g,f,e,d,c,b,a}, active-low.
- digit  out  NUM_DIGITS  digit enables, active-low one-hot.

Behaviour:
- The design has one clock (fast_clk). Reset is synchronous and active-high (rst); it is sampled only on the rising edge of fast_clk.

Reset (takes priority over all other inputs, including mid-phase):
- phase=RED, remaining=RED_T, light=3'b100, clock=0.
- Tick counter=0, scan counter=0, scan index=0, digit=~1 (digit0 enabled), ped_latch=0.

Tick generator:
- Counter runs 0..TICK_DIV-1 and wraps to 0.
- clock=1 for exactly the cycle in which the counter equals TICK_DIV-1.
- The counter keeps running while hold=1, but ticks are ignored by the FSM.

FSM:
- Transitions RED->GREEN->YELLOW->RED.
- On each tick with hold=0:
  - if remaining>1: remaining decrements;
  - if remaining==1: advance phase and load the new phase's duration (GREEN_T, YELLOW_T or RED_T).
- Phase, light and remaining update the cycle after the tick cycle (1-cycle latency).
- light is registered and always one-hot, including through reset.

Pedestrian request:
- ped_req=1 in any cycle sets ped_latch.
- Service happens in the first cycle where phase==GREEN and hold=0:
  - if remaining>PED_MIN, load remaining=PED_MIN;
  - in all cases clear ped_latch.
- A request made during RED or YELLOW is held until the next GREEN.
- Tick and pedestrian service in the same cycle: the load of PED_MIN wins and the decrement is dropped.
- Requests during hold are latched and serviced after hold falls.

Display:
- remaining is kept in two BCD digits (tens, units) updated together with the binary count, never converted combinationally from a wide value.
- The scan counter advances the scan index every SCAN_DIV cycles, wrapping NUM_DIGITS-1 -> 0.
- Digit contents by scan index:
  - index 0 = units;
  - index 1 = tens, blanked (seg=8'hFF) when tens==0;
  - index NUM_DIGITS-1 = phase glyph 'r' / 'G' / 'y';
  - all other indices blank.
- seg and digit are registered and change in the same cycle; dp is always off.
- hold does not stop the scan.

Decomposition:
- Shared package:
  - phase encodings;
  - active-low seven-segment constants for 0-9, blank, 'r', 'G', 'y';
  - lamp one-hot constants.
- One sub-module, seg7_scan: scan counter, digit rotation, glyph selection, seg/digit registers. It is parametrised by NUM_DIGITS and SCAN_DIV and takes BCD digits plus phase.
- The FSM, tick divider and BCD down-counter stay in the parent.

Test Plan:
All scenarios use TICK_DIV=4, SCAN_DIV=2, RED_T=4, GREEN_T=5, YELLOW_T=2, PED_MIN=2, NUM_DIGITS=4.
1. Reset then free-run -> clock pulses every 4 cycles; light sequence 100 for 4 ticks, 001 for 5 ticks, 010 for 2 ticks, then 100; full cycle 44 fast_clk cycles.
2. Display scan in RED with remaining=4 -> digit cycles 1110,1101,1011,0111, each held 2 cycles; seg=units '4', then blank, then blank, then 'r'.
3. ped_req pulsed 1 cycle during RED -> GREEN starts with remaining 5; forced to 2 one cycle after GREEN entry; YELLOW after 2 ticks.
4. ped_req during GREEN with remaining=1 -> no change; latch cleared; a second ped_req in the following RED forces the next GREEN to 2.
5. hold high for 12 cycles mid-GREEN at remaining=3 -> remaining and light constant; digit scan continues; after release the countdown resumes from 3.
6. rst asserted mid-YELLOW for 1 cycle -> next cycle light=100, remaining=4, digit=1110, tick counter restarts so the first clock pulse comes 4 cycles later.

Source files
------------

// File: rtl/traffic_display_ctrl_pkg.sv
// Shared encodings for the traffic sequencer: phases, lamp patterns, active-low glyphs.
// Helper functions here are constant lookups only; no wide arithmetic reaches the datapath.
package traffic_display_ctrl_pkg;

  typedef enum logic [1:0] {
    PH_RED    = 2'b00,
    PH_GREEN  = 2'b01,
    PH_YELLOW = 2'b10
  } phase_e;

  // {dp,g,f,e,d,c,b,a}, a segment is lit when its bit is 0
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_R     = 8'hAF;
  localparam logic [7:0] SEG_G     = 8'hC2;
  localparam logic [7:0] SEG_Y     = 8'h91;

  localparam logic [0:2] LAMP_RED    = 3'b100;
  localparam logic [0:2] LAMP_YELLOW = 3'b010;
  localparam logic [0:2] LAMP_GREEN  = 3'b001;

  function automatic logic [7:0] seg_digit(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  function automatic logic [7:0] phase_glyph(input phase_e p);
    case (p)
      PH_GREEN:  return SEG_G;
      PH_YELLOW: return SEG_Y;
      default:   return SEG_R;
    endcase
  endfunction

  function automatic logic [0:2] lamp_of(input phase_e p);
    case (p)
      PH_GREEN:  return LAMP_GREEN;
      PH_YELLOW: return LAMP_YELLOW;
      default:   return LAMP_RED;
    endcase
  endfunction

  // Only ever called on elaboration constants (phase durations, PED_MIN)
  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

endpackage

// File: rtl/traffic_display_ctrl_if.sv
// Lamp, tick, display and request signals of the traffic controller.
// The slave modport is the controller side, master is whatever drives the requests.
interface traffic_display_ctrl_if #(
  parameter int NUM_DIGITS = 4
);
  logic                  ped_req;
  logic                  hold;
  logic [0:2]            light;
  logic                  clock;
  logic [1:0]            phase;
  logic [7:0]            seg;
  logic [NUM_DIGITS-1:0] digit;

  modport master (output ped_req, hold, input light, clock, phase, seg, digit);
  modport slave  (input ped_req, hold, output light, clock, phase, seg, digit);
endinterface

// File: rtl/traffic_display_ctrl_seg7_scan.sv
// Multiplexed seven-segment scanner: units, tens (leading-zero blanked), blanks, phase glyph.
// seg and digit are registered together, so both switch on the same edge.
module seg7_scan
  import traffic_display_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            tens_i,
  input  logic [3:0]            units_i,
  input  phase_e                phase_i,
  output logic [7:0]            seg_o,
  output logic [NUM_DIGITS-1:0] digit_o
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NUM_DIGITS);
  localparam logic [SW-1:0]         SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]         IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0  = NUM_DIGITS'(1);

  logic [SW-1:0]         scan_q, scan_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [7:0]            seg_q, seg_d;
  logic [NUM_DIGITS-1:0] digit_q, digit_d;

  always_comb begin
    scan_d = scan_q + 1'b1;
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    digit_d = ~(ONE_HOT0 << idx_d);

    // Glyph is chosen for the slot being entered so seg and digit stay aligned
    seg_d = SEG_BLANK;
    if (idx_d == IDX_LAST) begin
      seg_d = phase_glyph(phase_i);
    end else if (idx_d == '0) begin
      seg_d = seg_digit(units_i);
    end else if (idx_d == IW'(1)) begin
      seg_d = (tens_i == 4'd0) ? SEG_BLANK : seg_digit(tens_i);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q  <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_BLANK;
      digit_q <= ~ONE_HOT0;
    end else begin
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      digit_q <= digit_d;
    end
  end

  assign seg_o   = seg_q;
  assign digit_o = digit_q;

endmodule

// File: rtl/traffic_display_ctrl.sv
// Traffic-light sequencer with tick divider, pedestrian shortening, hold, and BCD countdown display.
// Phase, lamps and remaining count update one cycle after the tick (or pedestrian service) cycle.
module traffic_display_ctrl
  import traffic_display_ctrl_pkg::*;
#(
  parameter int TICK_DIV   = 50_000_000,
  parameter int SCAN_DIV   = 50_000,
  parameter int RED_T      = 10,
  parameter int GREEN_T    = 8,
  parameter int YELLOW_T   = 3,
  parameter int PED_MIN    = 2,
  parameter int NUM_DIGITS = 4
) (
  input  logic                  fast_clk,
  input  logic                  rst,
  traffic_display_ctrl_if.slave io
);

  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [6:0]    PED_MIN_B = 7'(PED_MIN);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  phase_e        phase_q, phase_d;
  logic [6:0]    rem_q, rem_d;
  logic [3:0]    tens_q, tens_d, units_q, units_d;
  logic [0:2]    light_q, light_d;
  logic          ped_q, ped_d;
  logic          tick, serve;

  function automatic logic [6:0] dur_of(input phase_e p);
    case (p)
      PH_GREEN:  return 7'(GREEN_T);
      PH_YELLOW: return 7'(YELLOW_T);
      default:   return 7'(RED_T);
    endcase
  endfunction

  function automatic logic [7:0] dur_bcd(input phase_e p);
    case (p)
      PH_GREEN:  return to_bcd(GREEN_T);
      PH_YELLOW: return to_bcd(YELLOW_T);
      default:   return to_bcd(RED_T);
    endcase
  endfunction

  function automatic phase_e next_phase(input phase_e p);
    case (p)
      PH_RED:   return PH_GREEN;
      PH_GREEN: return PH_YELLOW;
      default:  return PH_RED;
    endcase
  endfunction

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    serve      = ped_q && (phase_q == PH_GREEN) && !io.hold;
    ped_d      = io.ped_req || (ped_q && !serve);

    phase_d = phase_q;
    rem_d   = rem_q;
    tens_d  = tens_q;
    units_d = units_q;
    // Pedestrian shortening takes precedence over a coincident tick
    if (serve && (rem_q > PED_MIN_B)) begin
      rem_d             = PED_MIN_B;
      {tens_d, units_d} = to_bcd(PED_MIN);
    end else if (tick && !io.hold) begin
      if (rem_q > 7'd1) begin
        rem_d = rem_q - 7'd1;
        if (units_q == 4'd0) begin
          units_d = 4'd9;
          tens_d  = tens_q - 4'd1;
        end else begin
          units_d = units_q - 4'd1;
        end
      end else begin
        phase_d           = next_phase(phase_q);
        rem_d             = dur_of(phase_d);
        {tens_d, units_d} = dur_bcd(phase_d);
      end
    end
    light_d = lamp_of(phase_d);
  end

  always_ff @(posedge fast_clk) begin
    if (rst) begin
      tick_cnt_q        <= '0;
      phase_q           <= PH_RED;
      rem_q             <= 7'(RED_T);
      {tens_q, units_q} <= to_bcd(RED_T);
      light_q           <= LAMP_RED;
      ped_q             <= 1'b0;
    end else begin
      tick_cnt_q        <= tick_cnt_d;
      phase_q           <= phase_d;
      rem_q             <= rem_d;
      {tens_q, units_q} <= {tens_d, units_d};
      light_q           <= light_d;
      ped_q             <= ped_d;
    end
  end

  assign io.light = light_q;
  assign io.clock = tick;
  assign io.phase = phase_q;

  seg7_scan #(
    .NUM_DIGITS (NUM_DIGITS),
    .SCAN_DIV   (SCAN_DIV)
  ) u_scan (
    .clk     (fast_clk),
    .rst     (rst),
    .tens_i  (tens_q),
    .units_i (units_q),
    .phase_i (phase_q),
    .seg_o   (io.seg),
    .digit_o (io.digit)
  );

endmodule
